ppu_stream: RTL and testbench

- Parametrised successor pixel-processing unit: generates or forwards one pixel word per output handshake for the VGA pixel stream.
- Input words are buffered in a real FIFO with backpressure; the output is held until accepted.
- Screen position advances per delivered pixel, not per clock, so the unit never runs ahead of the consumer.
- Sits between the host/data source and the VGA timing/DAC stage.

---
 rtl/ppu_stream_if.sv | 24 ++
 rtl/ppu_stream.sv | 184 ++++++++++++++++++
 tb/tb_ppu_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_stream_if.sv
// Pixel stream handshake bundle: input words towards the unit (data_i/stb_i/ack_i)
// and generated pixels towards the VGA timing/DAC stage (data_o/stb_o/ack_o).
interface ppu_stream_if #(
  parameter int PIX_W = 8
);
  logic [PIX_W-1:0] data_i;
  logic             stb_i;
  logic             ack_i;
  logic [PIX_W-1:0] data_o;
  logic             stb_o;
  logic             ack_o;

  // Host/data source on one side, consumer of pixels on the other.
  modport master (
    output data_i, stb_i, ack_o,
    input  ack_i, data_o, stb_o
  );

  // The pixel-processing unit itself.
  modport slave (
    input  data_i, stb_i, ack_o,
    output ack_i, data_o, stb_o
  );
endinterface

// File: rtl/ppu_stream.sv
// Pixel-processing unit: buffers input words in a FIFO and produces one pixel per
// output handshake, either forwarded from the FIFO or generated from the screen
// position (sx, sy) and an animation counter. Position only advances when a
// pixel is actually delivered, so the unit never runs ahead of its consumer.
// A pixel is computed from the position registers as they stand in the cycle it
// is loaded, i.e. before the advance caused by a transfer in that same cycle.
module ppu_stream #(
  parameter int PIX_W      = 8,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int FIFO_DEPTH = 16,
  parameter int ANIM_DIV   = 2,
  parameter int PC_W       = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync,
  input  logic [2:0]                  mode,
  ppu_stream_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_tick
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int XW   = $clog2(H_TOTAL);
  localparam int YW   = $clog2(V_TOTAL);
  localparam int DW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int MXY  = (XW > YW) ? XW : YW;
  localparam int SW   = ((MXY > PC_W) ? MXY : PC_W) + 1;
  localparam int PADW = 16;

  typedef enum logic [2:0] {
    MODE_PASS   = 3'd0,
    MODE_STRIPE = 3'd1,
    MODE_XOR    = 3'd2,
    MODE_CHECK  = 3'd3,
    MODE_FILL   = 3'd4
  } mode_e;

  // FIFO storage and bookkeeping
  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [PIX_W-1:0] head;

  // Output register, fill colour and screen state
  logic [PIX_W-1:0] data_q, latch_q;
  logic             stb_q;
  logic [XW-1:0]    sx;
  logic [YW-1:0]    sy;
  logic [DW-1:0]    div_q;
  logic [PC_W-1:0]  pc;

  // Pixel generation
  mode_e            mode_s;
  logic             load_en, out_xfer, gen_valid, last_x, last_y;
  logic [PIX_W-1:0] gen;
  logic [7:0]       pix8;
  logic [SW-1:0]    xs, ys, xr;
  logic [PADW-1:0]  sx_pad, sy_pad;
  logic             unused_pad_bits;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];
  assign bus.ack_i  = !full;
  assign push       = bus.stb_i && !full;
  assign fifo_level = count;

  assign mode_s    = mode_e'(mode);
  assign out_xfer  = stb_q && bus.ack_o;
  assign load_en   = !stb_q || bus.ack_o;
  assign gen_valid = !(mode_s == MODE_PASS && empty);
  assign pop       = load_en && !empty && (mode_s == MODE_PASS || mode_s == MODE_FILL);
  assign last_x    = (sx == XW'(H_TOTAL - 1));
  assign last_y    = (sy == YW'(V_TOTAL - 1));

  assign bus.data_o = data_q;
  assign bus.stb_o  = stb_q;

  // Padded position copies so fixed bit picks stay legal for small screen sizes.
  assign sx_pad          = PADW'(sx);
  assign sy_pad          = PADW'(sy);
  assign unused_pad_bits = ^{sx_pad[PADW-1:8], sx_pad[3:0], sy_pad[PADW-1:5], sy_pad[3:0]};

  // Next pixel for the selected source, from pre-advance sx/sy/pc.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    gen  = '0;
    pix8 = '0;
    xs   = SW'(sx) + SW'(pc);
    ys   = SW'(sy) + SW'(pc);
    xr   = xs ^ ys;
    unique case (mode_s)
      MODE_PASS: gen = head;
      MODE_STRIPE: begin
        pix8 = {{3{sx_pad[5]}}, {3{sx_pad[6]}}, {2{sx_pad[7]}}};
        if (PIX_W == 8) gen = PIX_W'(pix8);
        else            gen = {PIX_W{pix8[7]}};
      end
      MODE_XOR: begin
        pix8 = ((xr % SW'(7)) == '0) ? 8'hE0 : 8'h1C;
        if (PIX_W == 8) gen = PIX_W'(pix8);
        else            gen = {PIX_W{pix8[7]}};
      end
      MODE_CHECK: gen = {PIX_W{sx_pad[4] ^ sy_pad[4] ^ pc[0]}};
      MODE_FILL:  gen = empty ? latch_q : head;
      default:    gen = '0;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo FIFO_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count gates every read, so stale words are never observed.
    if (push) mem[wr_ptr] <= bus.data_i;
  end

  // Output register and fill colour: load whenever empty or handing off this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q   <= 1'b0;
      data_q  <= '0;
      latch_q <= '0;
    end else if (load_en) begin
      stb_q <= gen_valid;
      if (gen_valid) data_q <= gen;
      if (pop && mode_s == MODE_FILL) latch_q <= head;
    end
  end

  // Screen position, frame divider and animation counter, advanced per delivered pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx         <= '0;
      sy         <= '0;
      div_q      <= '0;
      pc         <= '0;
      frame_tick <= 1'b0;
    end else if (sync) begin
      sx         <= '0;
      sy         <= '0;
      div_q      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= out_xfer && last_x && last_y;
      if (out_xfer) begin
        if (last_x) begin
          sx <= '0;
          sy <= last_y ? '0 : sy + YW'(1);
        end else begin
          sx <= sx + XW'(1);
        end
        if (last_x && last_y) begin
          if (div_q == DW'(ANIM_DIV - 1)) begin
            div_q <= '0;
            pc    <= pc + PC_W'(1);
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_stream.sv
// Directed bench for ppu_stream: a full-size instance for line/FIFO/fill/sync
// behaviour and a small-screen instance (40x3) for frame and animation timing.
module tb_ppu_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic [2:0] mode;
  logic [4:0] fifo_level;
  logic       frame_tick;
  logic [2:0] s_fifo_level;
  logic       s_frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  ppu_stream_if #(.PIX_W(8)) bus  ();
  ppu_stream_if #(.PIX_W(8)) sbus ();

  ppu_stream u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .mode       (mode),
    .bus        (bus),
    .fifo_level (fifo_level),
    .frame_tick (frame_tick)
  );

  ppu_stream #(.H_TOTAL(40), .V_TOTAL(3), .FIFO_DEPTH(4), .ANIM_DIV(2)) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .mode       (mode),
    .bus        (sbus),
    .fifo_level (s_fifo_level),
    .frame_tick (s_frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sync        = 1'b0;
    mode        = 3'd0;
    bus.stb_i   = 1'b0;
    bus.data_i  = '0;
    bus.ack_o   = 1'b0;
    sbus.stb_i  = 1'b0;
    sbus.data_i = '0;
    sbus.ack_o  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] stripe(input int x);
    logic [31:0] v;
    v = x;
    return {{3{v[5]}}, {3{v[6]}}, {2{v[7]}}};
  endfunction

  initial begin
    int          xfers, ticks, first_tick, cyc;
    logic        prev_stb, prev_ack;
    logic [7:0]  prev_data;

    // Reset state, checked while reset is still asserted.
    rst_n = 1'b0; sync = 1'b0; mode = 3'd0;
    bus.stb_i = 1'b0; bus.data_i = '0; bus.ack_o = 1'b0;
    sbus.stb_i = 1'b0; sbus.data_i = '0; sbus.ack_o = 1'b0;
    tick();
    check("rst_stb_o", bus.stb_o, 1'b0);
    check("rst_ack_i", bus.ack_i, 1'b1);
    check("rst_data_o", bus.data_o, 8'h00);
    check("rst_level", fifo_level, 5'd0);
    check("rst_tick", frame_tick, 1'b0);

    // Stripes: first pixel from (0,0), then pixel k from sx = k-1.
    do_reset();
    mode = 3'd1;
    bus.ack_o = 1'b1;
    check("t1_idle_stb", bus.stb_o, 1'b0);
    tick();
    check("t1_first_stb", bus.stb_o, 1'b1);
    for (int k = 0; k < 800; k++) begin
      check("t1_pixel", {bus.stb_o, bus.data_o}, {1'b1, stripe((k == 0) ? 0 : k - 1)});
      if (k == 32) check("t1_sx31", bus.data_o, 8'h00);
      if (k == 33) check("t1_sx32", bus.data_o, 8'hE0);
      tick();
    end

    // Passthrough with backpressure: 0x01 sits in the output, 0x02..0x11 fill the FIFO.
    do_reset();
    mode = 3'd0;
    bus.ack_o = 1'b0;
    bus.stb_i = 1'b1;
    for (int w = 1; w <= 17; w++) begin
      bus.data_i = 8'(w);
      tick();
    end
    check("t2_full_level", fifo_level, 5'd16);
    check("t2_full_ack_i", bus.ack_i, 1'b0);
    check("t2_held", {bus.stb_o, bus.data_o}, {1'b1, 8'h01});
    bus.data_i = 8'h12;
    tick();
    check("t2_refuse_level", fifo_level, 5'd16);
    bus.stb_i = 1'b0;
    bus.ack_o = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      check("t2_drain", {bus.stb_o, bus.data_o}, {1'b1, 8'(k)});
      tick();
    end
    check("t2_empty_stb", bus.stb_o, 1'b0);
    check("t2_empty_level", fifo_level, 5'd0);

    // Small screen, ack_o toggling: holds while stalled, ticks at 120 and 240 transfers.
    do_reset();
    mode = 3'd1;
    xfers = 0; ticks = 0; first_tick = -1; cyc = 0;
    while (xfers < 240 && cyc < 2000) begin
      sbus.ack_o = ((cyc % 2) == 0);
      prev_stb  = sbus.stb_o;
      prev_data = sbus.data_o;
      prev_ack  = sbus.ack_o;
      tick();
      if (prev_stb && prev_ack) xfers++;
      if (!prev_ack) check("t3_hold", {sbus.stb_o, sbus.data_o}, {prev_stb, prev_data});
      if (s_frame_tick) begin
        ticks++;
        if (ticks == 1) first_tick = xfers;
      end
      cyc++;
    end
    check("t3_budget", xfers, 240);
    check("t3_tick_count", ticks, 2);
    check("t3_first_tick", first_tick, 120);
    sbus.ack_o = 1'b0;
    tick();
    mode = 3'd3;
    sbus.ack_o = 1'b1;
    tick();
    check("t3_pc_is_1", sbus.data_o, 8'hFF);

    // Fill mode: latch follows each word popped from the FIFO.
    do_reset();
    mode = 3'd4;
    bus.ack_o = 1'b1;
    bus.stb_i = 1'b1;
    bus.data_i = 8'hE0;
    tick();
    bus.stb_i = 1'b0;
    check("t4_latch0", {bus.stb_o, bus.data_o}, {1'b1, 8'h00});
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t4_fill_e0", {bus.stb_o, bus.data_o}, {1'b1, 8'hE0});
      tick();
    end
    bus.stb_i = 1'b1;
    bus.data_i = 8'h1C;
    tick();
    bus.stb_i = 1'b0;
    check("t4_still_e0", bus.data_o, 8'hE0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_fill_1c", {bus.stb_o, bus.data_o}, {1'b1, 8'h1C});
      tick();
    end
    check("t4_level", fifo_level, 5'd0);

    // Sync at (100,3) during a transfer, xor pattern with pc=0.
    do_reset();
    mode = 3'd2;
    bus.ack_o = 1'b1;
    tick();
    repeat (2500) tick();
    check("t5_pre_99_3", bus.data_o, 8'h1C);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t5_at_100_3", bus.data_o, 8'h1C);
    check("t5_no_tick", frame_tick, 1'b0);
    tick();
    check("t5_after_sync_0_0", bus.data_o, 8'hE0);
    tick();
    check("t5_then_1_0", bus.data_o, 8'h1C);

    // Sync on the last pixel of a small frame suppresses frame_tick and restarts the frame.
    do_reset();
    mode = 3'd1;
    sbus.ack_o = 1'b1;
    tick();
    repeat (119) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("t5s_tick_suppressed", s_frame_tick, 1'b0);
    ticks = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (s_frame_tick) ticks++;
    end
    check("t5s_one_tick", ticks, 1);
    check("t5s_tick_last", s_frame_tick, 1'b1);

    // Asynchronous reset mid-stream with five words queued and a pixel held.
    do_reset();
    mode = 3'd0;
    bus.ack_o = 1'b0;
    bus.stb_i = 1'b1;
    for (int w = 0; w < 6; w++) begin
      bus.data_i = 8'hA1 + 8'(w);
      tick();
    end
    bus.stb_i = 1'b0;
    check("t6_level5", fifo_level, 5'd5);
    check("t6_held", {bus.stb_o, bus.data_o}, {1'b1, 8'hA1});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_stb", bus.stb_o, 1'b0);
    check("t6_rst_data", bus.data_o, 8'h00);
    check("t6_rst_level", fifo_level, 5'd0);
    check("t6_rst_ack_i", bus.ack_i, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_after_stb", bus.stb_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
